// File: rtl/mode_queue_pkg.sv
// mode_queue_pkg
// Shared definitions for the mode_queue slice.
//   mode_e          : queue flavour chosen at elaboration time
//   calc_ptr_width  : pointer width for a given depth (a depth of 1 still
//                     gets a 1-bit pointer, which is simply held at 0)
package mode_queue_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        PIPE   = 2'd1,
        BYPASS = 2'd2
    } mode_e;

    function automatic int calc_ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mode_queue_ctrl.sv
// mode_queue_ctrl
// Pointer, occupancy and ready logic for mode_queue. Holds no payload.
// Ports:
//   clk, reset         : clock, asynchronous active-high reset
//   clear_i            : synchronous flush (zeros pointers and count)
//   enq_en_i, deq_en_i : fire strobes from the queue ports
//   enq_rdy_o, deq_rdy_o : handshake readiness
//   wr_en_o, wr_ptr_o  : storage write strobe and slot
//   rd_ptr_o           : head slot for the output mux
//   bypass_o           : head is taken straight from the enqueue payload
//   count_o            : number of stored entries
//
// Handshake: a side fires on a cycle where its _en and _rdy are both high.
// _en without _rdy is ignored and leaves all state untouched.
module mode_queue_ctrl
    import mode_queue_pkg::*;
#(
    parameter int    num_entries = 2,
    parameter mode_e mode        = NORMAL,
    parameter int    count_width = $clog2(num_entries + 1),
    parameter int    ptr_width   = calc_ptr_width(num_entries)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   enq_en_i,
    input  logic                   deq_en_i,
    output logic                   enq_rdy_o,
    output logic                   deq_rdy_o,
    output logic                   wr_en_o,
    output logic [ptr_width-1:0]   wr_ptr_o,
    output logic [ptr_width-1:0]   rd_ptr_o,
    output logic                   bypass_o,
    output logic [count_width-1:0] count_o
);

    localparam logic [ptr_width-1:0]   LAST_PTR   = ptr_width'(num_entries - 1);
    localparam logic [count_width-1:0] FULL_COUNT = count_width'(num_entries);

    logic [ptr_width-1:0]   enq_ptr_q, enq_ptr_d;
    logic [ptr_width-1:0]   deq_ptr_q, deq_ptr_d;
    logic [count_width-1:0] count_q, count_d;

    logic full, empty;
    logic enq_extra, deq_extra;
    logic enq_fire, deq_fire, pass_fire, rd_adv;

    function automatic logic [ptr_width-1:0] ptr_inc(input logic [ptr_width-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // Mode-specific readiness extensions.
    generate
        if (mode == PIPE) begin : g_pipe
            // A full queue can still accept when the head leaves this cycle.
            assign enq_extra = full & deq_en_i;
        end else begin : g_no_pipe
            assign enq_extra = 1'b0;
        end
        if (mode == BYPASS) begin : g_bypass
            // An empty queue can deliver the incoming payload directly.
            assign deq_extra = empty & enq_en_i;
        end else begin : g_no_bypass
            assign deq_extra = 1'b0;
        end
    endgenerate

    assign enq_rdy_o = ~reset & ~clear_i & (~full  | enq_extra);
    assign deq_rdy_o = ~reset & ~clear_i & (~empty | deq_extra);

    assign enq_fire  = enq_en_i & enq_rdy_o;
    assign deq_fire  = deq_en_i & deq_rdy_o;

    // Pass-through on an empty BYPASS queue: the payload never lands in storage.
    assign pass_fire = deq_extra & enq_fire & deq_fire;
    assign wr_en_o   = enq_fire & ~pass_fire;
    assign rd_adv    = deq_fire & ~pass_fire;

    assign wr_ptr_o  = enq_ptr_q;
    assign rd_ptr_o  = deq_ptr_q;
    assign bypass_o  = deq_extra;
    assign count_o   = count_q;

    always_comb begin
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        count_d   = count_q;
        if (clear_i) begin
            enq_ptr_d = '0;
            deq_ptr_d = '0;
            count_d   = '0;
        end else begin
            if (wr_en_o) enq_ptr_d = ptr_inc(enq_ptr_q);
            if (rd_adv)  deq_ptr_d = ptr_inc(deq_ptr_q);
            if (wr_en_o && !rd_adv) begin
                count_d = count_q + 1'b1;
            end else if (!wr_en_o && rd_adv) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enq_ptr_q <= '0;
            deq_ptr_q <= '0;
            count_q   <= '0;
        end else begin
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/mode_queue.sv
// mode_queue
// Circular-buffer queue with an elaboration-time mode (NORMAL, PIPE, BYPASS).
// Ports:
//   clk      : clock, all state on rising edge
//   reset    : asynchronous active-high reset (storage contents are kept)
//   clear    : synchronous flush
//   enq_en / enq_rdy / enq_msg : enqueue handshake and payload
//   deq_en / deq_rdy / deq_msg : dequeue handshake and head payload
//   count    : number of stored entries
//
// Handshake: a side fires on a cycle where its _en and _rdy are both high.
// deq_msg is only meaningful while deq_rdy is high.
module mode_queue
    import mode_queue_pkg::*;
#(
    parameter int    data_width  = 32,
    parameter int    num_entries = 2,
    parameter mode_e mode        = NORMAL,
    parameter int    count_width = $clog2(num_entries + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   enq_en,
    output logic                   enq_rdy,
    input  logic [data_width-1:0]  enq_msg,
    input  logic                   deq_en,
    output logic                   deq_rdy,
    output logic [data_width-1:0]  deq_msg,
    output logic [count_width-1:0] count
);

    localparam int PTR_W = calc_ptr_width(num_entries);

    logic [data_width-1:0] mem_q [num_entries];
    logic                  wr_en;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  bypass;

    mode_queue_ctrl #(
        .num_entries (num_entries),
        .mode        (mode),
        .count_width (count_width),
        .ptr_width   (PTR_W)
    ) u_ctrl (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (clear),
        .enq_en_i  (enq_en),
        .deq_en_i  (deq_en),
        .enq_rdy_o (enq_rdy),
        .deq_rdy_o (deq_rdy),
        .wr_en_o   (wr_en),
        .wr_ptr_o  (wr_ptr),
        .rd_ptr_o  (rd_ptr),
        .bypass_o  (bypass),
        .count_o   (count)
    );

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= enq_msg;
        end
    end

    assign deq_msg = bypass ? enq_msg : mem_q[rd_ptr];

endmodule

// File: tb/tb_mode_queue.sv
`timescale 1ns/1ps
module tb_mode_queue;
  import mode_queue_pkg::*;

  localparam int NI = 7;
  // Instance table: 0 N2, 1 P2, 2 B2, 3 N3, 4 N1, 5 P1, 6 B3
  localparam mode_e MODES [NI] = '{NORMAL, PIPE, BYPASS, NORMAL, NORMAL, PIPE, BYPASS};
  localparam int    NS    [NI] = '{2, 2, 2, 3, 1, 1, 3};

  logic clk = 1'b0;
  logic reset;
  logic [NI-1:0]      clear;
  logic [NI-1:0]      enq_en;
  logic [NI-1:0]      deq_en;
  logic [NI-1:0][7:0] enq_msg;
  logic [NI-1:0]      enq_rdy;
  logic [NI-1:0]      deq_rdy;
  logic [NI-1:0][7:0] deq_msg;
  logic [NI-1:0][3:0] cnt;

  logic [7:0] exp_q [NI][$];

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      mode_queue #(
        .data_width  (8),
        .num_entries (NS[g]),
        .mode        (MODES[g]),
        .count_width (4)
      ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear[g]),
        .enq_en  (enq_en[g]),
        .enq_rdy (enq_rdy[g]),
        .enq_msg (enq_msg[g]),
        .deq_en  (deq_en[g]),
        .deq_rdy (deq_rdy[g]),
        .deq_msg (deq_msg[g]),
        .count   (cnt[g])
      );
    end
  endgenerate

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    enq_en = '0;
    deq_en = '0;
    clear  = '0;
  endtask

  // One clock: check every instance against the model just before the edge,
  // then retire the transactions the model says fired.
  task automatic cycle();
    bit ef [NI];
    bit df [NI];
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      int   sz;
      logic er, dr;
      sz = exp_q[i].size();
      er = !reset && !clear[i] && (sz < NS[i] || (MODES[i] == PIPE && sz == NS[i] && deq_en[i]));
      dr = !reset && !clear[i] && (sz > 0 || (MODES[i] == BYPASS && enq_en[i]));
      chk("count", i, cnt[i], sz);
      chk("enq_rdy", i, enq_rdy[i], er);
      chk("deq_rdy", i, deq_rdy[i], dr);
      if (dr) chk("deq_msg", i, deq_msg[i], (sz > 0) ? exp_q[i][0] : enq_msg[i]);
      ef[i] = enq_en[i] && er;
      df[i] = deq_en[i] && dr;
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (reset || clear[i]) begin
        exp_q[i].delete();
      end else if (ef[i] && df[i] && exp_q[i].size() == 0) begin
        // pass-through: nothing stored
      end else begin
        if (df[i]) void'(exp_q[i].pop_front());
        if (ef[i]) exp_q[i].push_back(enq_msg[i]);
      end
    end
    #1;
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic async_reset();
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      chk("rst_count", i, cnt[i], 0);
      chk("rst_enq_rdy", i, enq_rdy[i], 0);
      chk("rst_deq_rdy", i, deq_rdy[i], 0);
    end
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    enq_msg = '0;
    idle();
    async_reset();
    cycle();

    // Two-deep NORMAL fill and drain
    enq_en[0] = 1'b1; enq_msg[0] = 8'hA1; cycle();
    enq_msg[0] = 8'hB2; cycle();
    idle(); #1;
    chk("r031_count", 0, cnt[0], 2);
    chk("r031_enq_rdy", 0, enq_rdy[0], 0);
    deq_en[0] = 1'b1; #1;
    chk("r031_deq0", 0, deq_msg[0], 8'hA1);
    cycle(); #1;
    chk("r031_deq1", 0, deq_msg[0], 8'hB2);
    cycle(); idle(); #1;
    chk("r031_empty_cnt", 0, cnt[0], 0);
    chk("r031_empty_rdy", 0, deq_rdy[0], 0);

    // PIPE full with simultaneous enq/deq
    enq_en[1] = 1'b1; enq_msg[1] = 8'h11; cycle();
    enq_msg[1] = 8'h22; cycle();
    enq_msg[1] = 8'h33; deq_en[1] = 1'b1; #1;
    chk("r032_enq_rdy", 1, enq_rdy[1], 1);
    chk("r032_deq", 1, deq_msg[1], 8'h11);
    chk("r032_count", 1, cnt[1], 2);
    cycle(); idle(); #1;
    chk("r032_count_after", 1, cnt[1], 2);
    chk("r032_head", 1, deq_msg[1], 8'h22);
    deq_en[1] = 1'b1; cycle(); cycle(); idle();

    // BYPASS zero-latency pass-through
    enq_en[2] = 1'b1; enq_msg[2] = 8'h5C; deq_en[2] = 1'b1; #1;
    chk("r033_deq_rdy", 2, deq_rdy[2], 1);
    chk("r033_deq_msg", 2, deq_msg[2], 8'h5C);
    chk("r033_count", 2, cnt[2], 0);
    cycle(); idle(); #1;
    chk("r033_count_after", 2, cnt[2], 0);
    chk("r033_deq_rdy_after", 2, deq_rdy[2], 0);

    // Depth-3 staggered stream forcing pointer wrap
    enq_en[3] = 1'b1; enq_msg[3] = 8'd1; cycle();
    for (int k = 2; k <= 7; k++) begin
      enq_msg[3] = 8'(k); deq_en[3] = 1'b1; #1;
      chk("r034_order", 3, deq_msg[3], k - 1);
      cycle();
    end
    enq_en[3] = 1'b0; deq_en[3] = 1'b1; #1;
    chk("r034_last", 3, deq_msg[3], 7);
    cycle(); idle(); #1;
    chk("r034_empty", 3, cnt[3], 0);

    // Clear overrides a same-cycle enqueue
    enq_en[3] = 1'b1; enq_msg[3] = 8'h41; cycle();
    enq_msg[3] = 8'h42; cycle();
    enq_msg[3] = 8'h99; clear[3] = 1'b1; #1;
    chk("r035_clr_enq_rdy", 3, enq_rdy[3], 0);
    chk("r035_clr_deq_rdy", 3, deq_rdy[3], 0);
    cycle(); idle(); #1;
    chk("r035_clr_count", 3, cnt[3], 0);
    chk("r035_clr_deq_rdy_after", 3, deq_rdy[3], 0);
    enq_en[3] = 1'b1; enq_msg[3] = 8'h77; cycle(); idle(); #1;
    chk("r035_post_clear_head", 3, deq_msg[3], 8'h77);
    deq_en[3] = 1'b1; cycle(); idle();

    // Reset mid-stream discards stored entries
    enq_en[0] = 1'b1; enq_msg[0] = 8'h01; cycle();
    enq_msg[0] = 8'h02; cycle(); idle();
    async_reset();
    cycle();

    // Single-entry NORMAL
    enq_en[4] = 1'b1; enq_msg[4] = 8'hFF; cycle(); idle(); #1;
    chk("r036_enq_rdy", 4, enq_rdy[4], 0);
    chk("r036_deq_rdy", 4, deq_rdy[4], 1);
    enq_en[4] = 1'b1; enq_msg[4] = 8'h00; cycle(); idle(); #1;
    chk("r036_count", 4, cnt[4], 1);
    chk("r036_head_kept", 4, deq_msg[4], 8'hFF);
    deq_en[4] = 1'b1; cycle(); idle(); #1;
    chk("r036_empty", 4, cnt[4], 0);
    chk("r036_empty_rdy", 4, deq_rdy[4], 0);

    // Randomized traffic on all instances, enq-heavy then deq-heavy
    for (int c = 0; c < 500; c++) begin
      int pe, pd;
      pe = (c < 250) ? 70 : 40;
      pd = (c < 250) ? 40 : 70;
      for (int i = 0; i < NI; i++) begin
        enq_en[i]  = ($urandom_range(0, 99) < pe);
        deq_en[i]  = ($urandom_range(0, 99) < pd);
        clear[i]   = ($urandom_range(0, 39) == 0);
        enq_msg[i] = 8'($urandom);
      end
      if (c == 300) begin
        idle();
        async_reset();
      end else begin
        cycle();
      end
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mode_queue.md
MODE_QUEUE -- requirements
Module: mode_queue

Interface
REQ-001 Parameter data_width, default 32, payload width in bits (>=1).
REQ-002 Parameter num_entries, default 2, storage depth (>=1, need not be a power of two).
REQ-003 Parameter mode, default NORMAL, queue mode_e: NORMAL, PIPE or BYPASS.
REQ-004 Parameter count_width, default clog2(num_entries+1), width of count.
REQ-005 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-006 Port reset  input  1  asynchronous, active-high reset.
REQ-007 Port clear  input  1  synchronous flush request.
REQ-008 Port enq_en  input  1  enqueue fire strobe.
REQ-009 Port enq_rdy  output  1  enqueue may fire this cycle.
REQ-010 Port enq_msg  input  data_width  enqueue payload.
REQ-011 Port deq_en  input  1  dequeue fire strobe.
REQ-012 Port deq_rdy  output  1  dequeue may fire this cycle.
REQ-013 Port deq_msg  output  data_width  head payload.
REQ-014 Port count  output  count_width  number of stored entries.

Function
REQ-015 Storage SHALL be a circular buffer; enq_ptr/deq_ptr wrap from num_entries-1 to 0; num_entries=1 uses a 1-bit pointer held at 0.
REQ-016 An enq fire (enq_en & enq_rdy) SHALL write enq_msg at enq_ptr; enq_en without enq_rdy SHALL be ignored (no state change).
REQ-017 A deq fire (deq_en & deq_rdy) SHALL advance deq_ptr; deq_en without deq_rdy SHALL be ignored.
REQ-018 count SHALL increment on enq-only fire, decrement on deq-only fire, hold on both/none; never exceeds num_entries nor underflows.
REQ-019 NORMAL: enq_rdy = count<num_entries; deq_rdy = count>0; deq_msg = entry at deq_ptr; no combinational in-to-out paths.
REQ-020 PIPE: as NORMAL, plus enq_rdy=1 when full and deq_en=1 same cycle; full with both fires advances both pointers, count unchanged (sustained full-rate throughput at depth num_entries).
REQ-021 BYPASS: as NORMAL, plus deq_rdy=1 when empty and enq_en=1, with deq_msg=enq_msg combinationally; empty with both fires writes nothing, pointers and count unchanged (zero-latency pass-through).
REQ-022 NORMAL/PIPE latency enq fire -> deq_rdy SHALL be exactly 1 cycle; BYPASS latency SHALL be 0 cycles when empty.
REQ-023 clear=1 SHALL zero both pointers and count at the next edge, override any same-cycle enq/deq, and force enq_rdy=deq_rdy=0 that cycle.
REQ-024 deq_msg SHALL be don't-care when deq_rdy=0.

Reset
REQ-025 reset assertion SHALL immediately (asynchronously) zero enq_ptr, deq_ptr and count.
REQ-026 While reset=1 enq_rdy and deq_rdy SHALL be 0; first edge after deassertion shows enq_rdy=1, deq_rdy=0 (BYPASS: deq_rdy follows enq_en).
REQ-027 Data storage SHALL NOT be reset; reset mid-stream discards all entries.

Structure
REQ-028 Package mode_queue_pkg SHALL hold typedef mode_e (NORMAL=0, PIPE=1, BYPASS=2).
REQ-029 Sub-module mode_queue_ctrl SHALL hold pointers, count, mode-dependent rdy logic; top SHALL hold the data array and output mux.
REQ-030 Mode selection SHALL be elaboration-time (generate), no runtime mode port.

Verification
REQ-031 NORMAL, n=2, w=8: enq 0xA1, 0xB2 -> count=2, enq_rdy=0; deq twice -> 0xA1 then 0xB2, count=0, deq_rdy=0.
REQ-032 PIPE, n=2: fill with 0x11,0x22; then enq 0x33 with deq same cycle -> enq_rdy=1, deq returns 0x11, count stays 2, next head 0x22.
REQ-033 BYPASS, n=2 empty: enq_en=1 0x5C with deq_en=1 -> deq_rdy=1, deq_msg=0x5C same cycle, count stays 0.
REQ-034 NORMAL, n=3: 7 enq/deq pairs staggered by one entry -> pointers wrap 2->0, output order 1..7 preserved.
REQ-035 Any mode: count=2, assert reset between edges -> count=0, rdys=0 immediately; clear with enq_en=1 -> count=0 next cycle, no write.
REQ-036 n=1 NORMAL: enq 0xFF -> enq_rdy=0, deq_rdy=1 next cycle; deq -> empty; enq_en while full ignored.
